// File: rtl/ex_alu_stage.sv
// Execute stage: operand forwarding, a four-operation ALU and the EX/MEM pipeline register.
// Results appear one cycle after the inputs are sampled; stall holds, flush bubbles, reset clears.
module ex_alu_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] exmem_fwd,
  input  logic [XLEN-1:0] memwb_fwd,
  input  logic [4:0]      rd_in,
  input  logic            reg_write_in,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic            branch_in,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd_out,
  output logic            reg_write_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic            branch_taken,
  output logic            illegal_op
);

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic            alu_zero;
  logic            alu_illegal;

  // Code 11 falls back to the register file value, same as 00.
  always_comb begin
    fwd_a = rs1_data;
    case (forward_a)
      2'b10:   fwd_a = exmem_fwd;
      2'b01:   fwd_a = memwb_fwd;
      default: fwd_a = rs1_data;
    endcase
  end

  always_comb begin
    fwd_b = rs2_data;
    case (forward_b)
      2'b10:   fwd_b = exmem_fwd;
      2'b01:   fwd_b = memwb_fwd;
      default: fwd_b = rs2_data;
    endcase
  end

  assign op_b = alu_src ? imm : fwd_b;

  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (alu_ctrl)
      AluAdd:  alu_res = fwd_a + op_b;
      AluSub:  alu_res = fwd_a - op_b;
      AluAnd:  alu_res = fwd_a & op_b;
      AluOr:   alu_res = fwd_a | op_b;
      default: alu_illegal = 1'b1;
    endcase
  end

  assign alu_zero = (alu_res == '0);

  // Reset and flush both empty the slot; reset wins over stall as well.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid     <= 1'b0;
      alu_result    <= '0;
      zero          <= 1'b0;
      store_data    <= '0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
      branch_taken  <= 1'b0;
      illegal_op    <= 1'b0;
    end else if (!stall) begin
      out_valid     <= in_valid;
      alu_result    <= alu_res;
      zero          <= alu_zero;
      store_data    <= fwd_b;
      rd_out        <= rd_in;
      reg_write_out <= reg_write_in & in_valid;
      mem_read_out  <= mem_read_in & in_valid;
      mem_write_out <= mem_write_in & in_valid;
      branch_taken  <= branch_in & alu_zero & in_valid;
      illegal_op    <= alu_illegal & in_valid;
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Bench for ex_alu_stage: directed vectors push expected EX/MEM contents into a queue,
// a negedge monitor pops and compares them against the registered outputs.
module tb_ex_alu_stage;

  localparam int unsigned XLEN = 64;
  localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] result;
    logic            zero;
    logic [XLEN-1:0] store;
    logic [4:0]      rd;
    logic            rw;
    logic            mr;
    logic            mw;
    logic            bt;
    logic            ill;
  } out_t;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            stall;
  logic            flush;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic            alu_src;
  logic [1:0]      forward_a;
  logic [1:0]      forward_b;
  logic [XLEN-1:0] exmem_fwd;
  logic [XLEN-1:0] memwb_fwd;
  logic [4:0]      rd_in;
  logic            reg_write_in;
  logic            mem_read_in;
  logic            mem_write_in;
  logic            branch_in;
  logic            out_valid;
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic [XLEN-1:0] store_data;
  logic [4:0]      rd_out;
  logic            reg_write_out;
  logic            mem_read_out;
  logic            mem_write_out;
  logic            branch_taken;
  logic            illegal_op;

  ex_alu_stage #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .stall         (stall),
    .flush         (flush),
    .alu_ctrl      (alu_ctrl),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .imm           (imm),
    .alu_src       (alu_src),
    .forward_a     (forward_a),
    .forward_b     (forward_b),
    .exmem_fwd     (exmem_fwd),
    .memwb_fwd     (memwb_fwd),
    .rd_in         (rd_in),
    .reg_write_in  (reg_write_in),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .branch_in     (branch_in),
    .out_valid     (out_valid),
    .alu_result    (alu_result),
    .zero          (zero),
    .store_data    (store_data),
    .rd_out        (rd_out),
    .reg_write_out (reg_write_out),
    .mem_read_out  (mem_read_out),
    .mem_write_out (mem_write_out),
    .branch_taken  (branch_taken),
    .illegal_op    (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  out_t  exp_q[$];
  string name_q[$];
  int    n_total = 0;
  int    n_pass  = 0;

  function automatic out_t mk(input logic v, input logic [63:0] res, input logic z,
                              input logic [63:0] st, input logic [4:0] rd, input logic rw,
                              input logic mr, input logic mw, input logic bt, input logic il);
    out_t o;
    o.valid = v; o.result = res; o.zero = z; o.store = st; o.rd = rd;
    o.rw = rw; o.mr = mr; o.mw = mw; o.bt = bt; o.ill = il;
    return o;
  endfunction

  // Monitor: compares one expected entry per cycle, away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t  e;
      out_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = mk(out_valid, alu_result, zero, store_data, rd_out, reg_write_out, mem_read_out,
              mem_write_out, branch_taken, illegal_op);
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got v=%b res=%h z=%b st=%h rd=%0d rw=%b mr=%b mw=%b bt=%b il=%b ; want v=%b res=%h z=%b st=%h rd=%0d rw=%b mr=%b mw=%b bt=%b il=%b",
                    nm, a.valid, a.result, a.zero, a.store, a.rd, a.rw, a.mr, a.mw, a.bt, a.ill,
                    e.valid, e.result, e.zero, e.store, e.rd, e.rw, e.mr, e.mw, e.bt, e.ill);
    end
  end

  task automatic step(input string nm, input out_t e);
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; stall = 0; flush = 0; alu_ctrl = 4'b0010; rs1_data = '0; rs2_data = '0;
    imm = '0; alu_src = 0; forward_a = 0; forward_b = 0; exmem_fwd = '0; memwb_fwd = '0;
    rd_in = '0; reg_write_in = 0; mem_read_in = 0; mem_write_in = 0; branch_in = 0;
  endtask

  initial begin
    clear_inputs();
    // Reset with a live, valid instruction presented.
    reset = 1; in_valid = 1; rs1_data = 3; rs2_data = 4; rd_in = 9; reg_write_in = 1;
    step("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 0;

    clear_inputs();
    in_valid = 1; alu_ctrl = 4'b0010; rs1_data = 5; alu_src = 1; imm = Ones; rs2_data = 9;
    rd_in = 3; reg_write_in = 1;
    step("add_imm_neg1", mk(1, 4, 0, 9, 3, 1, 0, 0, 0, 0));

    clear_inputs();
    in_valid = 1; alu_ctrl = 4'b0110; rs1_data = 64'h1234; rs2_data = 64'h1234; branch_in = 1;
    step("sub_branch", mk(1, 0, 1, 64'h1234, 0, 0, 0, 0, 1, 0));

    clear_inputs();
    in_valid = 1; alu_ctrl = 4'b0001; forward_a = 2'b10; exmem_fwd = 64'hF0; rs1_data = 64'hAA;
    rs2_data = 64'h0F; rd_in = 5; reg_write_in = 1;
    step("or_fwd_exmem", mk(1, 64'hFF, 0, 64'h0F, 5, 1, 0, 0, 0, 0));

    clear_inputs();
    in_valid = 1; alu_ctrl = 4'b0010; rs1_data = 1; forward_b = 2'b01; memwb_fwd = 7;
    rs2_data = 100; mem_write_in = 1;
    step("store_fwd_memwb", mk(1, 8, 0, 7, 0, 0, 0, 1, 0, 0));

    clear_inputs();
    in_valid = 1; alu_ctrl = 4'b0010; forward_a = 2'b11; rs1_data = 10; exmem_fwd = 99;
    memwb_fwd = 77; forward_b = 2'b10; rs2_data = 1;
    step("fwd_a11_b10", mk(1, 109, 0, 99, 0, 0, 0, 0, 0, 0));

    clear_inputs();
    in_valid = 1; alu_ctrl = 4'b0000; rs1_data = 64'hF0F0; alu_src = 1; imm = 64'hFF00;
    rs2_data = 64'h55; mem_read_in = 1; rd_in = 12; reg_write_in = 1;
    step("and_imm_load", mk(1, 64'hF000, 0, 64'h55, 12, 1, 1, 0, 0, 0));

    clear_inputs();
    in_valid = 1; alu_ctrl = 4'b0010; rs1_data = Ones; rs2_data = 1; branch_in = 1;
    step("add_wrap", mk(1, 0, 1, 1, 0, 0, 0, 0, 1, 0));

    clear_inputs();
    in_valid = 1; alu_ctrl = 4'b1111; rs1_data = 5; rs2_data = 6; rd_in = 2; reg_write_in = 1;
    step("illegal_valid", mk(1, 0, 1, 6, 2, 1, 0, 0, 0, 1));
    in_valid = 0;
    step("illegal_invalid", mk(0, 0, 1, 6, 2, 0, 0, 0, 0, 0));

    clear_inputs();
    alu_ctrl = 4'b0010; rs1_data = 2; rs2_data = 3; reg_write_in = 1; mem_write_in = 1;
    branch_in = 1; rd_in = 4;
    step("bubble_gating", mk(0, 5, 0, 3, 4, 0, 0, 0, 0, 0));

    // Stall holds a captured ADD while inputs keep changing.
    clear_inputs();
    in_valid = 1; rs1_data = 64'h10; rs2_data = 64'h20; rd_in = 7; reg_write_in = 1;
    step("capture_add", mk(1, 64'h30, 0, 64'h20, 7, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      stall = 1; rs1_data = 64'(i + 100); rs2_data = 64'(i * 3); rd_in = 5'(20 + i);
      alu_ctrl = 4'b0110; mem_read_in = 1; in_valid = i[0];
      step("stall_hold", mk(1, 64'h30, 0, 64'h20, 7, 1, 0, 0, 0, 0));
    end
    flush = 1;
    step("stall_flush", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    clear_inputs();
    in_valid = 1; rs1_data = 1; rs2_data = 1; rd_in = 8; reg_write_in = 1;
    step("capture_pre_flush", mk(1, 2, 0, 1, 8, 1, 0, 0, 0, 0));
    flush = 1;
    step("flush_only", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset mid-stall drops the held instruction.
    clear_inputs();
    in_valid = 1; rs1_data = 40; rs2_data = 2; rd_in = 9; reg_write_in = 1; mem_write_in = 1;
    step("capture_pre_reset", mk(1, 42, 0, 2, 9, 1, 0, 1, 0, 0));
    stall = 1; rs1_data = 0;
    step("stall_pre_reset", mk(1, 42, 0, 2, 9, 1, 0, 1, 0, 0));
    reset = 1;
    step("reset_mid_stall", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 0;
    clear_inputs();
    in_valid = 1; alu_ctrl = 4'b0110; rs1_data = 0; rs2_data = 1; rd_in = 1; reg_write_in = 1;
    step("sub_after_reset", mk(1, Ones, 0, 1, 1, 1, 0, 0, 0, 0));
    clear_inputs();

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_alu_stage.md
EX_ALU_STAGE -- requirements
Module: ex_alu_stage

Interface
REQ-001 SHALL have parameter: XLEN, 64, datapath width in bits.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  ID/EX slot holds a real instruction.
REQ-005 SHALL have port: stall  input  1  hold EX/MEM register contents.
REQ-006 SHALL have port: flush  input  1  insert bubble into EX/MEM register.
REQ-007 SHALL have port: alu_ctrl  input  4  operation code: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR.
REQ-008 SHALL have ports: rs1_data, rs2_data, imm  input  XLEN each  register operands and sign-extended immediate.
REQ-009 SHALL have port: alu_src  input  1  1 selects imm as ALU operand B.
REQ-010 SHALL have ports: forward_a, forward_b  input  2 each  operand source select.
REQ-011 SHALL have ports: exmem_fwd, memwb_fwd  input  XLEN each  forwarded results.
REQ-012 SHALL have ports: rd_in  input  5; reg_write_in, mem_read_in, mem_write_in, branch_in  input  1 each  control passed down the pipe.
REQ-013 SHALL have ports: out_valid  output  1; alu_result  output  XLEN; zero  output  1; store_data  output  XLEN.
REQ-014 SHALL have ports: rd_out  output  5; reg_write_out, mem_read_out, mem_write_out, branch_taken, illegal_op  output  1 each.

Function
REQ-015 SHALL select forwarded operand A: forward_a 00 -> rs1_data, 10 -> exmem_fwd, 01 -> memwb_fwd, 11 -> rs1_data; forwarded B likewise from rs2_data via forward_b.
REQ-016 SHALL use operand B = imm when alu_src=1, else forwarded B; store_data SHALL always take forwarded B.
REQ-017 SHALL compute ADD and SUB modulo 2^XLEN (carry/borrow discarded, no overflow flag); AND and OR bitwise.
REQ-018 SHALL, for any other alu_ctrl code, produce result 0 and set illegal_op for that instruction when in_valid=1.
REQ-019 SHALL compute zero as (result == 0), registered alongside alu_result.
REQ-020 SHALL compute branch_taken as branch_in & zero & in_valid, registered.
REQ-021 SHALL have latency of exactly one cycle: inputs sampled at edge N appear on outputs after edge N.
REQ-022 SHALL, on an edge with reset=0, flush=0, stall=0, capture: out_valid=in_valid, data outputs from current inputs, and control outputs (reg_write, mem_read, mem_write, branch_taken, illegal_op) gated by in_valid.
REQ-023 SHALL, on an edge with stall=1 and flush=0, hold every output unchanged.
REQ-024 SHALL give flush priority over stall: clear out_valid, all control outputs, rd_out, alu_result, store_data and zero to 0.
REQ-025 SHALL give reset priority over flush and stall.
REQ-026 SHALL never assert reg_write_out, mem_read_out, mem_write_out, branch_taken or illegal_op while out_valid=0.

Reset
REQ-027 SHALL on reset drive out_valid, alu_result, zero, store_data, rd_out, reg_write_out, mem_read_out, mem_write_out, branch_taken and illegal_op to 0 after the next rising edge.
REQ-028 SHALL discard the in-flight instruction when reset asserts mid-stall; the first post-reset capture SHALL reflect only new inputs.

Verification
REQ-029 SHALL cover: alu_ctrl=0010, rs1=5, alu_src=1, imm=0xFFFF_FFFF_FFFF_FFFF -> alu_result=4, zero=0 one cycle later.
REQ-030 SHALL cover: alu_ctrl=0110, rs1=rs2=0x1234, branch_in=1, in_valid=1 -> alu_result=0, zero=1, branch_taken=1.
REQ-031 SHALL cover: forward_a=10, exmem_fwd=0xF0, rs2=0x0F, alu_ctrl=0001 -> alu_result=0xFF; forward_b=01, memwb_fwd=7, mem_write_in=1 -> store_data=7.
REQ-032 SHALL cover: valid ADD captured, then stall=1 for 3 cycles with changing inputs -> outputs unchanged; stall=1 with flush=1 -> out_valid=0, reg_write_out=0.
REQ-033 SHALL cover: alu_ctrl=1111, in_valid=1 -> alu_result=0, illegal_op=1; same with in_valid=0 -> illegal_op=0.
REQ-034 SHALL cover: reset=1 while out_valid=1 and stall=1 -> all outputs 0 after one edge; SUB of 0 minus 1 after release -> alu_result=all ones.
